// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared pipelined adder: grants one requester per
// cycle, registers its operands onto the adder and tags the result with its owner.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*W-1:0]          req_a,
  input  logic [NREQ*W-1:0]          req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic [W-1:0]               add_a,
  output logic [W-1:0]               add_b,
  input  logic [W:0]                 add_sum,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [W:0]                 rsp_sum,
  output logic [$clog2(LAT+3)-1:0]   inflight
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(LAT+3);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gidx_s;
  logic           any_s;
  logic           hs_s;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [LAT:0]   tv_q;
  logic [IDW-1:0] tid_q [0:LAT];
  logic [CW-1:0]  cnt_q, cnt_d;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return (s >= NREQ) ? IDW'(s - NREQ) : IDW'(s);
  endfunction

  // Round-robin search: first valid index at or after the pointer, wrapping.
  always_comb begin
    logic [IDW-1:0] cand;
    gidx_s = '0;
    any_s  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand   = wrap_add(ptr_q, i);
      gidx_s = (!any_s && req_valid[cand]) ? cand : gidx_s;
      any_s  = any_s | req_valid[cand];
    end
  end

  // One-hot grant, suppressed while reset is held.
  always_comb begin
    req_ready = '0;
    hs_s      = any_s & ~rst;
    if (hs_s) begin
      req_ready[gidx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state for pointer, issued operands and in-flight count.
  always_comb begin
    ptr_d = ptr_q;
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (hs_s) begin
      ptr_d = (gidx_s == IDW'(NREQ-1)) ? '0 : gidx_s + IDW'(1);
      a_d   = req_a[gidx_s*W +: W];
      b_d   = req_b[gidx_s*W +: W];
    end else begin
      ptr_d = ptr_q;
      a_d   = a_q;
      b_d   = b_q;
    end
    case ({hs_s, rsp_valid})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; the tag pipe mirrors the adder depth so tags meet their sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      tv_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k <= LAT; k++) begin
        tid_q[k] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      tv_q     <= {tv_q[LAT-1:0], hs_s};
      tid_q[0] <= gidx_s;
      for (int k = 1; k <= LAT; k++) begin
        tid_q[k] <= tid_q[k-1];
      end
    end
  end

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign rsp_valid = tv_q[LAT] & ~rst;
  assign rsp_id    = tid_q[LAT];
  assign rsp_sum   = add_sum;
  assign inflight  = cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural pipelined adder and a
// scoreboard queue drained by an independent response monitor.
module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int LAT  = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*W-1:0]     req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic [W-1:0]          add_a, add_b;
  logic [W:0]            add_sum;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [W:0]            rsp_sum;
  logic [1:0]            inflight;

  typedef struct packed {
    logic [1:0] id;
    logic [W:0] sum;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [W-1:0] op_a [NREQ];
  logic [W-1:0] op_b [NREQ];
  logic [W:0]   adder_pipe [LAT];

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .inflight(inflight)
  );

  // Shared adder stand-in with LAT register stages
  always_ff @(posedge clk) begin
    adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int k = 1; k < LAT; k++) adder_pipe[k] <= adder_pipe[k-1];
  end
  assign add_sum = adder_pipe[LAT-1];

  function automatic logic [W:0] fsum(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle, check grant/inflight mid-cycle, enqueue the expected response.
  task automatic cyc(input logic [NREQ-1:0] v, input logic r, input logic [NREQ-1:0] exp_ready,
                     input int exp_infl, input logic [W:0] exp_sum, input bit keep);
    exp_t e;
    req_valid = v;
    rst       = r;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (exp_infl >= 0) chk("inflight", 32'(inflight), 32'(exp_infl));
    if (keep) begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_ready[i]) begin
          e.id  = 2'(i);
          e.sum = exp_sum;
          sb_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000, 1'b0, 4'b0000, -1, 17'h0, 1'b0);
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d sum=%h expected no response at t=%0t",
                 rsp_id, rsp_sum, $time);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    cyc(4'b1111, 1'b1, 4'b0000, 0, 17'h0, 1'b0);
    chk("reset_add_a", 32'(add_a), 32'h0);
    chk("reset_add_b", 32'(add_b), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    idle(1);

    // Test 1: lone requester 2
    op_a[2] = 16'h1234; op_b[2] = 16'h0001;
    cyc(4'b0100, 1'b0, 4'b0100, 0, 17'h01235, 1'b1);
    cyc(4'b0000, 1'b0, 4'b0000, 1, 17'h0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1, 17'h0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 0, 17'h0, 1'b0);
    idle(1);

    // Test 4: carry out kept (pointer at 3, wraps to requester 0)
    op_a[0] = 16'hFFFF; op_b[0] = 16'h0001;
    cyc(4'b0001, 1'b0, 4'b0001, 0, 17'h10000, 1'b1);
    op_a[0] = 16'hFFFF; op_b[0] = 16'hFFFF;
    cyc(4'b0001, 1'b0, 4'b0001, 1, 17'h1FFFE, 1'b1);
    idle(3);

    // Test 3: pointer at 1, only 0 and 3 valid
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 16'(16'h1000 * (i + 1) + 16'h0010);
      op_b[i] = 16'(16'h0101 * (i + 1));
    end
    cyc(4'b1001, 1'b0, 4'b1000, 0, fsum(op_a[3], op_b[3]), 1'b1);
    cyc(4'b1001, 1'b0, 4'b0001, 1, fsum(op_a[0], op_b[0]), 1'b1);
    cyc(4'b1001, 1'b0, 4'b1000, 2, fsum(op_a[3], op_b[3]), 1'b1);
    idle(3);

    // Test 2: all requesters valid for 8 cycles, operands change each cycle
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = 16'(c * 16'h0100 + i * 16'h1111);
        op_b[i] = 16'(16'hF000 + c * 16'h0011 + i);
      end
      cyc(4'b1111, 1'b0, 4'(1 << (c % 4)), (c < 2) ? c : 2,
          fsum(op_a[c % 4], op_b[c % 4]), 1'b1);
    end
    idle(2);

    // Test 5: two accepted ops discarded by reset
    op_a[0] = 16'h5555; op_b[0] = 16'h1111;
    op_a[1] = 16'h6666; op_b[1] = 16'h2222;
    cyc(4'b0011, 1'b0, 4'b0001, 0, 17'h0, 1'b0);
    cyc(4'b0011, 1'b0, 4'b0010, 1, 17'h0, 1'b0);
    req_valid = 4'b0011;
    rst       = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    op_a[1] = 16'hABCD; op_b[1] = 16'h0102;
    op_a[2] = 16'h0F0F; op_b[2] = 16'h0F0F;
    cyc(4'b0110, 1'b0, 4'b0010, 0, 17'h0ACCF, 1'b1);
    idle(3);

    // Test 6: idle, operands on the adder hold the last grant
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0000, 1'b0, 4'b0000, 0, 17'h0, 1'b0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("idle_add_a", 32'(add_a), 32'h0000ABCD);
      chk("idle_add_b", 32'(add_b), 32'h00000102);
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
